ship_projectile_renderer: RTL

- Owns the player-ship projectile: accepts fire requests, moves the shot up one step per frame, and retires it when it leaves the screen or a hit is reported.
- On the pixel side it is the reader of the projectile sprite table. It turns the VGA DrawX/DrawY position into sprite-local SpriteX/SpriteY, samples the returned RGB, and presents a registered pixel plus a valid (opaque) flag to the colour mapper.

---
 rtl/ship_projectile_renderer_pkg.sv | 15 +
 rtl/ship_projectile_renderer_pixel_pipe.sv | 61 ++++++
 rtl/ship_projectile_renderer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/ship_projectile_renderer_pkg.sv
// Shared types and sprite defaults for the player-ship projectile renderer.
package ship_projectile_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLYING   = 2'd1,
        COOLDOWN = 2'd2
    } proj_state_t;

    localparam int SPRITE_W_DEF = 3;
    localparam int SPRITE_H_DEF = 8;

    typedef logic [23:0] rgb_t;

endpackage

// File: rtl/ship_projectile_renderer_pixel_pipe.sv
// Two-stage pixel path: DrawX/DrawY -> sprite-local address (stage 1),
// sprite-table RGB -> registered pixel with opaque flag (stage 2).
module proj_pixel_pipe
    import ship_projectile_pkg::*;
#(
    parameter int SPRITE_W = SPRITE_W_DEF,
    parameter int SPRITE_H = SPRITE_H_DEF
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic [9:0] PosX,
    input  logic [9:0] PosY,
    input  logic       Active,
    input  rgb_t       SpriteRgb,
    output logic [9:0] SpriteX,
    output logic [9:0] SpriteY,
    output rgb_t       PixelRgb,
    output logic       PixelValid
);

    logic [9:0] dx;
    logic [9:0] dy;
    logic       inBox;
    logic       inBoxQ;
    logic       opaque;

    // Sprite-local offsets; a draw position left of/above the shot wraps large and falls outside the box.
    always_comb begin
        dx     = DrawX - PosX;
        dy     = DrawY - PosY;
        inBox  = Active && (dx < 10'(SPRITE_W)) && (dy < 10'(SPRITE_H));
        opaque = inBoxQ && (SpriteRgb != '0);
    end

    // Stage 1: register the sprite-table address, parked at 0 outside the box.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            SpriteX <= '0;
            SpriteY <= '0;
            inBoxQ  <= 1'b0;
        end else begin
            SpriteX <= inBox ? dx : 10'd0;
            SpriteY <= inBox ? dy : 10'd0;
            inBoxQ  <= inBox;
        end
    end

    // Stage 2: register the sampled colour; black texels count as transparent.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            PixelRgb   <= '0;
            PixelValid <= 1'b0;
        end else begin
            PixelRgb   <= opaque ? SpriteRgb : '0;
            PixelValid <= opaque;
        end
    end

endmodule

// File: rtl/ship_projectile_renderer.sv
// Player-ship projectile: fire/fly/cooldown FSM, per-frame motion and the
// sprite pixel pipeline.
// Build option: PROJ_AUTOFIRE_EN makes Fire level-sensitive (held Fire
// relaunches after cooldown); by default only a rising edge of Fire launches.
//
// state    | meaning
// IDLE     | no shot on screen, waiting for an accepted fire
// FLYING   | shot in flight, moves up SPEED pixels per frame tick
// COOLDOWN | shot retired, counting frame ticks before fire is re-armed
module ship_projectile_renderer
    import ship_projectile_pkg::*;
#(
    parameter int SPRITE_W        = SPRITE_W_DEF,
    parameter int SPRITE_H        = SPRITE_H_DEF,
    parameter int SPEED           = 4,
    parameter int NOSE_OFFSET     = 1,
    parameter int COOLDOWN_FRAMES = 2
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       Fire,
    input  logic       Hit,
    input  logic [9:0] ShipX,
    input  logic [9:0] ShipY,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic [9:0] SpriteX,
    output logic [9:0] SpriteY,
    input  logic [7:0] SpriteR,
    input  logic [7:0] SpriteG,
    input  logic [7:0] SpriteB,
    output logic [7:0] PixelR,
    output logic [7:0] PixelG,
    output logic [7:0] PixelB,
    output logic       PixelValid,
    output logic       Active,
    output logic [9:0] PosX,
    output logic [9:0] PosY
);

    proj_state_t state;
    proj_state_t nextState;
    logic        frameClkD;
    logic        fireD;
    logic        tick;
    logic        fireAccept;
    logic        fireGuardOk;
    logic [3:0]  cooldownCnt;
    rgb_t        pixelRgb;

    // Frame tick and fire qualification.
    always_comb begin
        tick        = frame_clk & ~frameClkD;
        fireGuardOk = (ShipY >= 10'(SPRITE_H)) && (ShipX >= 10'(NOSE_OFFSET));
`ifdef PROJ_AUTOFIRE_EN
        fireAccept  = Fire;
`else
        fireAccept  = Fire & ~fireD;
`endif
    end

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= nextState;
    end

    // Next-state logic; Hit takes priority over a coincident tick.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:     if (fireAccept && fireGuardOk) nextState = FLYING;
            FLYING: begin
                if (Hit)                                nextState = COOLDOWN;
                else if (tick && (PosY < 10'(SPEED)))   nextState = COOLDOWN;
            end
            COOLDOWN: if (tick && (cooldownCnt == 4'd1)) nextState = IDLE;
            default:  nextState = IDLE;
        endcase
    end

    // Output decode.
    always_comb begin
        Active = (state == FLYING);
    end

    // Edge registers, projectile position and cooldown counter.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frameClkD   <= 1'b0;
            fireD       <= 1'b0;
            PosX        <= '0;
            PosY        <= '0;
            cooldownCnt <= '0;
        end else begin
            frameClkD <= frame_clk;
            fireD     <= Fire;
            if (state == IDLE && nextState == FLYING) begin
                PosX <= ShipX - 10'(NOSE_OFFSET);
                PosY <= ShipY - 10'(SPRITE_H);
            end else if (state == FLYING && !Hit && tick && (PosY >= 10'(SPEED))) begin
                PosY <= PosY - 10'(SPEED);
            end
            if (state != COOLDOWN && nextState == COOLDOWN)
                cooldownCnt <= 4'(COOLDOWN_FRAMES);
            else if (state == COOLDOWN && tick)
                cooldownCnt <= cooldownCnt - 4'd1;
        end
    end

    proj_pixel_pipe #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H)
    ) uPixelPipe (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .PosX       (PosX),
        .PosY       (PosY),
        .Active     (Active),
        .SpriteRgb  ({SpriteR, SpriteG, SpriteB}),
        .SpriteX    (SpriteX),
        .SpriteY    (SpriteY),
        .PixelRgb   (pixelRgb),
        .PixelValid (PixelValid)
    );

    assign {PixelR, PixelG, PixelB} = pixelRgb;

endmodule
